// File: rtl/am_ctrl_pkg.sv
// Shared types and Q1.15 saturating helpers for the AM sweep controller.
package am_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN
    } am_state_e;

    localparam logic [15:0] Q15_ONE = 16'd32767;

    // Sum is formed at 17 bits so a large step can never wrap past the limit.
    function automatic logic [15:0] q15_sat_add(input logic [15:0] a, input logic [15:0] b,
                                                input logic [15:0] lim);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[15:0];
    endfunction

    function automatic logic [15:0] q15_sat_sub(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? (a - b) : 16'd0;
    endfunction

endpackage

// File: rtl/am_tick_gen.sv
// Ramp-tick prescaler: one-cycle tick every RATE_DIV clocks while not cleared.
module am_tick_gen #(
    parameter logic [15:0] RATE_DIV = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    logic [15:0] cnt_q, cnt_d;

    assign o_tick = !i_clear && (cnt_q == RATE_DIV - 16'd1);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (i_clear || o_tick) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/am_sweep_ctrl.sv
// AM envelope sequencer: ramp depth up, hold, ramp down, then signal done.
// Define AM_SWEEP_LOOP_EN to repeat the sweep until a stop request.
module am_sweep_ctrl
    import am_ctrl_pkg::*;
#(
    parameter logic [15:0] DEPTH_INC = 16'd1024,
    parameter logic [15:0] RATE_DIV  = 16'd50000,
    parameter int unsigned HOLD_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [31:0]       i_step,
    input  logic [15:0]       i_depth_q15,
    input  logic [HOLD_W-1:0] i_hold,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_nco_enable,
    output logic [31:0]       o_step,
    output logic [15:0]       o_depth_q15,
    output logic              o_done
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = 1;

    am_state_e         state_q;
    logic              busy_q, ready_q, done_q;
    logic [31:0]       step_q;
    logic [15:0]       depth_q, target_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [15:0]       depth_up, depth_dn, target_in;
    logic              tick, tick_clear;

`ifdef AM_SWEEP_LOOP_EN
    logic [HOLD_W-1:0] hold_q;
    logic              stop_q;
`endif

    assign tick_clear = (state_q == IDLE);

    am_tick_gen #(
        .RATE_DIV(RATE_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(tick_clear),
        .o_tick (tick)
    );

    assign depth_up  = q15_sat_add(depth_q, DEPTH_INC, target_q);
    assign depth_dn  = q15_sat_sub(depth_q, DEPTH_INC);
    assign target_in = (i_depth_q15 > Q15_ONE) ? Q15_ONE : i_depth_q15;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            step_q     <= 32'd0;
            depth_q    <= 16'd0;
            target_q   <= 16'd0;
            hold_cnt_q <= '0;
`ifdef AM_SWEEP_LOOP_EN
            hold_q     <= '0;
            stop_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef AM_SWEEP_LOOP_EN
            stop_q <= (state_q == IDLE) ? 1'b0 : (stop_q | i_stop);
`endif
            unique case (state_q)
                IDLE: begin
                    // A stop arriving with the start is intentionally dropped.
                    if (i_start) begin
                        step_q     <= i_step;
                        target_q   <= target_in;
                        hold_cnt_q <= i_hold;
`ifdef AM_SWEEP_LOOP_EN
                        hold_q     <= i_hold;
`endif
                        depth_q    <= 16'd0;
                        state_q    <= RAMP_UP;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                    end
                end
                RAMP_UP: begin
                    if (i_stop) begin
                        state_q <= RAMP_DOWN;
                    end else if (tick) begin
                        depth_q <= depth_up;
                        if (depth_up == target_q) begin
                            state_q <= (hold_cnt_q == '0) ? RAMP_DOWN : HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (i_stop) begin
                        state_q <= RAMP_DOWN;
                    end else if (tick) begin
                        hold_cnt_q <= hold_cnt_q - HOLD_ONE;
                        if (hold_cnt_q == HOLD_ONE) begin
                            state_q <= RAMP_DOWN;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (tick) begin
                        depth_q <= depth_dn;
                        if (depth_dn == 16'd0) begin
                            done_q <= 1'b1;
`ifdef AM_SWEEP_LOOP_EN
                            if (stop_q || i_stop) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                            end else begin
                                state_q    <= RAMP_UP;
                                hold_cnt_q <= hold_q;
                            end
`else
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
`endif
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready      = ready_q;
    assign o_busy       = busy_q;
    assign o_nco_enable = busy_q;
    assign o_step       = step_q;
    assign o_depth_q15  = depth_q;
    assign o_done       = done_q;

endmodule

// File: doc/am_sweep_ctrl.md
Name: am_sweep_ctrl

Overview:
- Run-time sequencer for the AM envelope NCO.
- On a start request it latches the envelope step and target depth, then drives the NCO enable.
- It ramps the depth from 0 up to the target, holds it for a programmed number of ticks, ramps it back to 0, and signals completion.
- It sits between the control/register interface and the NCO's step/depth/enable inputs, giving click-free AM fade-in and fade-out.

Parameters:
- DEPTH_INC, 16'd1024: depth increment/decrement per ramp tick, in Q1.15.
- RATE_DIV, 16'd50000: clocks per ramp tick; legal range ≥1 (1 µs ticks at 50 MHz is 50).
- HOLD_W, 16: width of the hold-count input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start request; accepted only when o_ready=1.
- i_stop  in  1  abort request; forces the ramp-down phase.
- i_step  in  32  NCO phase increment; latched on start accept.
- i_depth_q15  in  16  target depth; latched on accept, clamped to 32767.
- i_hold  in  HOLD_W  hold duration in ticks; latched on accept.
- o_ready  out  1  high in IDLE only.
- o_busy  out  1  high in RAMP_UP, HOLD and RAMP_DOWN.
- o_nco_enable  out  1  NCO enable; equal to o_busy.
- o_step  out  32  latched step driven to the NCO.
- o_depth_q15  out  16  current depth driven to the NCO.
- o_done  out  1  single-cycle pulse at sequence end.

Behaviour:
- Reset (async assert, sync release) puts the block in IDLE:
  - o_step=0, o_depth_q15=0, o_busy=0, o_nco_enable=0, o_done=0, o_ready=1.
  - Tick prescaler=0, hold counter=0, stop latch=0.
- Registered outputs; all change on the clock edge after the causing event.
- Tick generator:
  - Counts 0..RATE_DIV-1, and tick=1 in the cycle where count==RATE_DIV-1.
  - Cleared on start accept, and held at 0 in IDLE.
- IDLE:
  - i_start=1 gives accept: latch step, target=min(i_depth_q15,32767), and hold.
  - Go to RAMP_UP, with depth starting at 0.
  - i_stop is ignored in IDLE. If start and stop are asserted together in IDLE, the start is accepted and the stop is discarded.
- RAMP_UP:
  - On each tick, depth=min(depth+DEPTH_INC, target), computed at 17 bits with no wrap.
  - When depth==target after an update, go to HOLD; go straight to RAMP_DOWN if hold==0.
  - If target==0, go to HOLD/RAMP_DOWN on the first tick.
- HOLD:
  - The hold counter decrements on each tick from the latched value.
  - When it reaches 0, go to RAMP_DOWN.
- RAMP_DOWN:
  - On each tick, depth=max(depth-DEPTH_INC, 0), saturating.
  - When depth reaches 0, go to IDLE and pulse o_done for one cycle.
  - o_nco_enable drops in the same cycle, which resets the NCO phase.
- i_stop in RAMP_UP or HOLD: go to RAMP_DOWN on the next clock, starting from the current depth. The prescaler is not reset.
- i_stop in RAMP_DOWN: no effect.
- i_start while busy: ignored, since o_ready=0.
- Mid-sequence reset: immediately to the reset state, with no o_done pulse.
- o_step is constant while busy; it retains its last value in IDLE, but is 0 after reset.

Optional Feature:
- Macro: AM_SWEEP_LOOP_EN.
- Defined:
  - RAMP_DOWN reaching 0 returns to RAMP_UP, with depth 0 and the same latched settings.
  - o_done pulses at each loop end and o_nco_enable stays high.
  - i_stop sets a stop latch: the current phase goes to RAMP_DOWN as normal, and the next 0 exit goes to IDLE.
  - The stop latch clears in IDLE.
- Undefined: single-shot as described in Behaviour; no stop-latch register is present.

Decomposition:
- Package am_ctrl_pkg:
  - State enum: IDLE, RAMP_UP, HOLD, RAMP_DOWN (2 bits).
  - Q15_ONE=16'd32767.
  - Saturating add/sub functions for Q1.15.
- Sub-module am_tick_gen (RATE_DIV parameter; clk, rst_n, i_clear, o_tick).
- The ramp/hold FSM is inline in am_sweep_ctrl.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-HOLD.
  - Response: all outputs go to reset values asynchronously, o_done stays 0, and o_ready=1 after release.
- Single-shot sweep:
  - Stimulus: DEPTH_INC=4096, RATE_DIV=4, start with depth 16384, hold 2.
  - Response: depth steps 4096/8192/12288/16384 every 4 clocks, holds for 8 clocks, ramps down 12288..0, then one o_done pulse and o_nco_enable=0.
- Clamp and saturation:
  - Stimulus: depth 40000, DEPTH_INC=12000.
  - Response: target 32767, ramp 12000/24000/32767, ramp-down 20767/8767/0 with no underflow.
- Abort:
  - Stimulus: i_stop at depth 8192 during RAMP_UP.
  - Response: the next state is RAMP_DOWN, depth follows 4096 then 0, then o_done.
- Handshake:
  - Stimulus: i_start while busy with a different i_step.
  - Response: ignored, and o_step is unchanged.
  - Stimulus: start+stop together in IDLE.
  - Response: the sweep starts.
- Loop (with AM_SWEEP_LOOP_EN):
  - Stimulus: run 3 cycles, then stop.
  - Response: o_done pulses once per cycle, o_nco_enable stays high throughout, and the block reaches IDLE after the stopped ramp-down.
